// File: rtl/pipe_buffer_if.sv
// Handshake bundle for pipe_buffer: upstream valid/ready, downstream valid/ready,
// and the side controls (clock enable, flush) and occupancy count.
interface pipe_buffer_if #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 2
);
    localparam int CW = $clog2(DEPTH + 1);

    logic             CE;
    logic             flush;
    logic             valid_in;
    logic [WIDTH-1:0] data_in;
    logic             ready_out;
    logic             valid_out;
    logic [WIDTH-1:0] data_out;
    logic             ready_in;
    logic [CW-1:0]    count;

    modport master (
        output CE, flush, valid_in, data_in, ready_in,
        input  ready_out, valid_out, data_out, count
    );

    modport slave (
        input  CE, flush, valid_in, data_in, ready_in,
        output ready_out, valid_out, data_out, count
    );
endinterface

// File: rtl/pipe_buffer.sv
// Elastic FIFO pipeline stage of DEPTH entries with circular pointers.
// Registered outputs only: a pushed word is visible one cycle later, never bypassed.
module pipe_buffer #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 2
) (
    input logic          CLK,
    input logic          RESETn,
    pipe_buffer_if.slave bus
);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q,  count_d;

    logic can_accept;
    logic has_data;
    logic push;
    logic pop;

    function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    // ready_out looks only at local state and the side controls, never at ready_in,
    // so a full buffer does not accept even when it is being drained this cycle.
    always_comb begin
        can_accept = RESETn & bus.CE & ~bus.flush & (count_q < CW'(DEPTH));
        has_data   = bus.CE & (count_q != '0);
        push       = bus.CE & bus.valid_in & can_accept & ~bus.flush;
        pop        = bus.CE & has_data & bus.ready_in & ~bus.flush;
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (bus.CE && bus.flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) wr_ptr_d = next_ptr(wr_ptr_q);
            if (pop)  rd_ptr_d = next_ptr(rd_ptr_q);
            if (push && !pop)      count_d = count_q + CW'(1);
            else if (pop && !push) count_d = count_q - CW'(1);
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples
    // the pre-edge values computed above, independent of statement order.
    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // NOTE: storage is reset on purpose so data_out reads zero during reset; this
    // costs a reset net on every bit, which is acceptable for a shallow buffer.
    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else if (push) begin
            mem_q[wr_ptr_q] <= bus.data_in;
        end
    end

    assign bus.ready_out = can_accept;
    assign bus.valid_out = has_data;
    assign bus.data_out  = mem_q[rd_ptr_q];
    assign bus.count     = count_q;
endmodule

// File: tb/tb_pipe_buffer.sv
// Drives a DEPTH=2 and a DEPTH=3 buffer with identical stimulus; each is checked
// every cycle against a queue model, and the DEPTH=2 one also against a vector table.
module tb_pipe_buffer;
    logic        CLK;
    logic        RESETn;
    logic        ce, flush, vin, rin;
    logic [31:0] din;

    int checks = 0;
    int errors = 0;

    logic [31:0] q2[$];
    logic [31:0] q3[$];

    pipe_buffer_if #(.WIDTH(32), .DEPTH(2)) bus2 ();
    pipe_buffer_if #(.WIDTH(32), .DEPTH(3)) bus3 ();

    assign bus2.CE = ce;  assign bus2.flush = flush; assign bus2.valid_in = vin;
    assign bus2.data_in = din; assign bus2.ready_in = rin;
    assign bus3.CE = ce;  assign bus3.flush = flush; assign bus3.valid_in = vin;
    assign bus3.data_in = din; assign bus3.ready_in = rin;

    pipe_buffer #(.WIDTH(32), .DEPTH(2)) dut2 (.CLK(CLK), .RESETn(RESETn), .bus(bus2));
    pipe_buffer #(.WIDTH(32), .DEPTH(3)) dut3 (.CLK(CLK), .RESETn(RESETn), .bus(bus3));

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct {
        logic        ce, flush, vin;
        logic [31:0] din;
        logic        rin;
        logic        ev, er;
        int          ec;
        logic [31:0] ed;
    } vec_t;

    vec_t vq[$];

    task automatic add(input logic c, f, v, input logic [31:0] d, input logic r,
                       input logic ev, er, input int ec, input logic [31:0] ed);
        vec_t t;
        t.ce = c; t.flush = f; t.vin = v; t.din = d; t.rin = r;
        t.ev = ev; t.er = er; t.ec = ec; t.ed = ed;
        vq.push_back(t);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_check(input string tag, input int depth, input int size,
                               input logic [31:0] front, input logic av, ar,
                               input logic [31:0] ad, input int ac,
                               output logic push, output logic pop);
        logic ev, er;
        ev = ce && (size != 0);
        er = ce && !flush && (size < depth);
        check({tag, " valid_out"}, 32'(av), 32'(ev));
        check({tag, " ready_out"}, 32'(ar), 32'(er));
        check({tag, " count"}, ac, size);
        if (ev) check({tag, " data_out"}, ad, front);
        push = ce && vin && er && !flush;
        pop  = ce && ev && rin && !flush;
    endtask

    // Called at the negedge sampling point; applies the clock edge to the models.
    task automatic sample_and_advance();
        logic p2, o2, p3, o3;
        model_check("d2", 2, q2.size(), (q2.size() != 0) ? q2[0] : 32'h0,
                    bus2.valid_out, bus2.ready_out, bus2.data_out, int'(bus2.count), p2, o2);
        model_check("d3", 3, q3.size(), (q3.size() != 0) ? q3[0] : 32'h0,
                    bus3.valid_out, bus3.ready_out, bus3.data_out, int'(bus3.count), p3, o3);
        if (ce && flush) begin
            q2.delete();
            q3.delete();
        end else begin
            if (o2) void'(q2.pop_front());
            if (p2) q2.push_back(din);
            if (o3) void'(q3.pop_front());
            if (p3) q3.push_back(din);
        end
        @(posedge CLK);
        #1;
    endtask

    initial begin
        // consecutive pushes with ready_in high: one-cycle latency, count steady at 1
        add(1,0,1,32'h1111_1111,1, 0,1,0,32'h0);
        add(1,0,1,32'h2222_2222,1, 1,1,1,32'h1111_1111);
        add(1,0,1,32'h3333_3333,1, 1,1,1,32'h2222_2222);
        add(1,0,0,32'h0,        1, 1,1,1,32'h3333_3333);
        add(1,0,0,32'h0,        1, 0,1,0,32'h0);
        // fill with downstream stalled, then drain
        add(1,0,1,32'hA,0, 0,1,0,32'h0);
        add(1,0,1,32'hB,0, 1,1,1,32'hA);
        add(1,0,1,32'hC,0, 1,0,2,32'hA);
        add(1,0,1,32'hC,1, 1,0,2,32'hA);
        add(1,0,1,32'hC,1, 1,1,1,32'hB);
        add(1,0,0,32'h0,1, 1,1,1,32'hC);
        add(1,0,0,32'h0,0, 0,1,0,32'h0);
        // clock-enable freeze while full
        add(1,0,1,32'hD1,0, 0,1,0,32'h0);
        add(1,0,1,32'hD2,0, 1,1,1,32'hD1);
        add(0,0,1,32'hEE,1, 0,0,2,32'h0);
        add(0,0,1,32'hEE,1, 0,0,2,32'h0);
        add(0,1,1,32'hEE,1, 0,0,2,32'h0);
        add(1,0,0,32'h0, 1, 1,0,2,32'hD1);
        add(1,0,0,32'h0, 1, 1,1,1,32'hD2);
        // flush while full with a word offered
        add(1,0,1,32'hF1,0, 0,1,0,32'h0);
        add(1,0,1,32'hF2,0, 1,1,1,32'hF1);
        add(1,1,1,32'hF3,1, 1,0,2,32'hF1);
        add(1,0,0,32'h0, 1, 0,1,0,32'h0);

        ce = 1'b1; flush = 1'b0; vin = 1'b0; rin = 1'b0; din = '0;
        RESETn = 1'b0;
        #2;
        check("reset valid_out", 32'(bus2.valid_out), 32'h0);
        check("reset ready_out", 32'(bus2.ready_out), 32'h0);
        check("reset count",     32'(bus2.count),     32'h0);
        check("reset data_out",  bus2.data_out,       32'h0);
        check("reset d3 ready_out", 32'(bus3.ready_out), 32'h0);
        @(negedge CLK);
        RESETn = 1'b1;
        @(posedge CLK);
        #1;

        foreach (vq[i]) begin
            ce = vq[i].ce; flush = vq[i].flush; vin = vq[i].vin;
            din = vq[i].din; rin = vq[i].rin;
            @(negedge CLK);
            check($sformatf("vec%0d valid_out", i), 32'(bus2.valid_out), 32'(vq[i].ev));
            check($sformatf("vec%0d ready_out", i), 32'(bus2.ready_out), 32'(vq[i].er));
            check($sformatf("vec%0d count", i),     32'(bus2.count),     vq[i].ec);
            if (vq[i].ev) check($sformatf("vec%0d data_out", i), bus2.data_out, vq[i].ed);
            sample_and_advance();
        end

        // asynchronous reset between edges with one entry held
        ce = 1'b1; flush = 1'b0; vin = 1'b1; rin = 1'b0; din = 32'h5A5A_5A5A;
        @(negedge CLK);
        sample_and_advance();
        vin = 1'b0;
        #1;
        check("pre-reset data_out", bus2.data_out,   32'h5A5A_5A5A);
        check("pre-reset count",    32'(bus2.count), 32'h1);
        #1;
        RESETn = 1'b0;
        #1;
        check("mid-reset valid_out", 32'(bus2.valid_out), 32'h0);
        check("mid-reset count",     32'(bus2.count),     32'h0);
        check("mid-reset data_out",  bus2.data_out,       32'h0);
        check("mid-reset ready_out", 32'(bus2.ready_out), 32'h0);
        check("mid-reset d3 count",  32'(bus3.count),     32'h0);
        q2.delete();
        q3.delete();
        @(negedge CLK);
        RESETn = 1'b1;
        @(posedge CLK);
        #1;

        // mixed random traffic; DEPTH=3 pointers wrap several times
        for (int i = 0; i < 40; i++) begin
            ce = 1'b1; flush = 1'b0;
            vin = ($urandom_range(0, 3) != 0);
            rin = (i < 12) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 1) != 0);
            din = $urandom;
            @(negedge CLK);
            sample_and_advance();
        end

        vin = 1'b0; rin = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge CLK);
            sample_and_advance();
        end
        check("drained d2 count", 32'(bus2.count), 32'h0);
        check("drained d3 count", 32'(bus3.count), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/pipe_buffer.md
PIPE_BUFFER -- requirements
Module: pipe_buffer

Interface
REQ-001 SHALL have parameter WIDTH, default 32, data path width in bits (>=1).
REQ-002 SHALL have parameter DEPTH, default 2, number of storage entries (>=1, any integer, not restricted to powers of two).
REQ-003 SHALL define CW = clog2(DEPTH+1), the width of count.
REQ-004 CLK  input  1  single clock; all state changes on rising edge.
REQ-005 RESETn  input  1  asynchronous, active-low reset.
REQ-006 CE  input  1  clock enable; low freezes all state.
REQ-007 flush  input  1  synchronous discard of all stored entries.
REQ-008 valid_in  input  1  upstream offers data_in.
REQ-009 data_in  input  WIDTH  upstream data.
REQ-010 ready_out  output  1  buffer can accept from upstream this cycle.
REQ-011 valid_out  output  1  data_out holds a valid entry.
REQ-012 data_out  output  WIDTH  oldest stored entry.
REQ-013 ready_in  input  1  downstream accepts data_out this cycle.
REQ-014 count  output  CW  number of entries held.

Function
REQ-015 SHALL be a first-in first-out elastic pipeline stage of DEPTH entries, with circular read/write pointers wrapping from DEPTH-1 to 0.
REQ-016 SHALL define push = CE & valid_in & ready_out & ~flush.
REQ-017 SHALL define pop = CE & valid_out & ready_in & ~flush.
REQ-018 ready_out SHALL equal CE & ~flush & (count < DEPTH), with no combinational dependence on ready_in.
REQ-019 valid_out SHALL equal CE & (count != 0).
REQ-020 data_out SHALL equal the entry at the read pointer, driven directly from storage; no combinational path from data_in.
REQ-021 Latency: a word pushed in cycle N SHALL first appear on valid_out/data_out in cycle N+1; there is no bypass.
REQ-022 On push only: the word SHALL be written at the write pointer, the write pointer SHALL advance, and count SHALL increase by 1.
REQ-023 On pop only: the read pointer SHALL advance and count SHALL decrease by 1.
REQ-024 On simultaneous push and pop: both pointers SHALL advance and count SHALL be unchanged; this is legal only when count < DEPTH, per REQ-018.
REQ-025 Full (count == DEPTH): ready_out SHALL be 0, and valid_in SHALL be held off without loss or corruption of stored data.
REQ-026 Empty (count == 0): valid_out SHALL be 0; data_out value is don't-care.
REQ-027 Throughput: DEPTH >= 2 SHALL sustain one transfer per cycle under continuous valid_in/ready_in; DEPTH = 1 SHALL sustain at most one transfer per two cycles.
REQ-028 CE low SHALL hold pointers, count and storage unchanged and force ready_out and valid_out to 0, regardless of valid_in, ready_in or flush.
REQ-029 flush high with CE high SHALL set count and both pointers to 0 on the next edge; no push or pop occurs that cycle, and storage contents are don't-care.
REQ-030 Data order SHALL be preserved exactly; no entry SHALL be duplicated or dropped except by flush or reset.

Reset
REQ-031 RESETn low SHALL immediately, without waiting for CLK, set count=0, both pointers=0, and all storage entries=0.
REQ-032 While RESETn is low: valid_out=0, ready_out=0, data_out=0.
REQ-033 Release of RESETn SHALL be treated as synchronous to CLK; the first push is possible on the first edge after release with CE=1.
REQ-034 Reset asserted mid-transfer SHALL discard all entries; no partial state SHALL survive.

Verification
REQ-035 Use WIDTH=32, DEPTH=2, CE=1, ready_in=1; push 0x11111111, 0x22222222, 0x33333333 on consecutive cycles -> each word appears one cycle later, in order, with valid_out held continuously and count steady at 1.
REQ-036 Use DEPTH=2, ready_in=0; push 0xA, 0xB, then 0xC -> count goes 1, 2; ready_out=0 after the second push and 0xC is not taken; then raise ready_in -> outputs 0xA, then 0xB, then 0xC is accepted.
REQ-037 With count=2, pulse CE=0 for 3 cycles while valid_in=1 and ready_in=1 -> count stays 2, valid_out=0 and ready_out=0 throughout; contents and order are intact after CE returns high.
REQ-038 With count=2, assert flush together with valid_in=1 and ready_in=1 -> next cycle count=0 and valid_out=0; the offered word is not stored.
REQ-039 Run a pointer wrap-around test with DEPTH=3 over 10 mixed push/pop cycles against a scoreboard -> full in-order match, and count always equals the scoreboard occupancy.
REQ-040 Assert RESETn low between clock edges while count=1 -> valid_out, count and data_out go to 0 before the next edge; after release, normal operation resumes.
